// File: rtl/enc_job_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// enc_job_scheduler_pkg
//   Shared definitions for the encrypt/decrypt job scheduler:
//   - FSM state encoding (IDLE, GRANT, START, WAIT, RESP)
//   - width helpers for message, key and requester-id buses
//   No ports; imported by enc_job_scheduler and rr_arbiter.
// ----------------------------------------------------------------------------
package enc_job_scheduler_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_GRANT = 3'd1;
   localparam logic [2:0] ST_START = 3'd2;
   localparam logic [2:0] ST_WAIT  = 3'd3;
   localparam logic [2:0] ST_RESP  = 3'd4;

   function automatic int msg_width(input int nb);
      return 32 * nb;
   endfunction

   function automatic int key_width(input int nk);
      return 32 * nk;
   endfunction

   // A single requester still needs a 1-bit id field.
   function automatic int id_width(input int nreq);
      return (nreq > 1) ? $clog2(nreq) : 1;
   endfunction

endpackage

// File: rtl/enc_job_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin search: returns the first set request bit at
//   or after ptr, wrapping cyclically over NREQ bits.
//   Ports:
//     req  [NREQ-1:0]  request vector
//     ptr  [ID_W-1:0]  search start position (0..NREQ-1)
//     any              at least one request is set
//     idx  [ID_W-1:0]  winning index (0 when any=0)
// ----------------------------------------------------------------------------
module rr_arbiter
   import enc_job_scheduler_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = id_width(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] ptr,
   output logic            any,
   output logic [ID_W-1:0] idx
);

   logic [ID_W-1:0] cand;

   // Scan from the farthest offset back to ptr so the closest hit is the
   // last assignment and therefore wins.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch can be inferred.
      any  = |req;
      idx  = '0;
      cand = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = ID_W'((int'(ptr) + k) % NREQ);
         if (req[cand]) idx = cand;
      end
   end

endmodule

// File: rtl/enc_job_scheduler.sv
// ----------------------------------------------------------------------------
// enc_job_scheduler
//   Round-robin scheduler sharing one serial encrypt/decrypt link master
//   among NREQ requesters. One job in flight at a time:
//   IDLE -> GRANT -> START -> WAIT -> RESP -> IDLE.
//   Optional feature macro: LINK_TIMEOUT_EN (WAIT watchdog, link_abort,
//   rsp_err). Without it link_abort and rsp_err are tied 0.
//   Ports:
//     in_clk, rst                 clock, async active-high reset
//     req_valid/req_ready         per-requester job handshake (ready one-hot)
//     req_msg/req_key/req_decrypt packed per-requester job payload
//     link_msg/link_key/link_decrypt  job held toward the link master
//     link_start/link_done/link_result/link_abort  link control/result
//     rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err  response channel
//     jobs_done                   16-bit wrapping completed-job counter
// ----------------------------------------------------------------------------
module enc_job_scheduler
   import enc_job_scheduler_pkg::*;
#(
   parameter int nb             = 4,
   parameter int nk             = 8,
   parameter int NREQ           = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                              in_clk,
   input  logic                              rst,
   input  logic [NREQ-1:0]                   req_valid,
   output logic [NREQ-1:0]                   req_ready,
   input  logic [NREQ*msg_width(nb)-1:0]     req_msg,
   input  logic [NREQ*key_width(nk)-1:0]     req_key,
   input  logic [NREQ-1:0]                   req_decrypt,
   output logic [msg_width(nb)-1:0]          link_msg,
   output logic [key_width(nk)-1:0]          link_key,
   output logic                              link_decrypt,
   output logic                              link_start,
   input  logic                              link_done,
   input  logic [msg_width(nb)-1:0]          link_result,
   output logic                              link_abort,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic [id_width(NREQ)-1:0]         rsp_id,
   output logic [msg_width(nb)-1:0]          rsp_data,
   output logic                              rsp_err,
   output logic [15:0]                       jobs_done
);

   localparam int MSG_W = msg_width(nb);
   localparam int KEY_W = key_width(nk);
   localparam int ID_W  = id_width(NREQ);

   logic [2:0]       state_q,        state_d;
   logic [ID_W-1:0]  grant_q,        grant_d;
   logic [ID_W-1:0]  rr_ptr_q,       rr_ptr_d;
   logic [MSG_W-1:0] link_msg_q,     link_msg_d;
   logic [KEY_W-1:0] link_key_q,     link_key_d;
   logic             link_decrypt_q, link_decrypt_d;
   logic [MSG_W-1:0] rsp_data_q,     rsp_data_d;
   logic [15:0]      jobs_done_q,    jobs_done_d;

   logic             arb_any;
   logic [ID_W-1:0]  arb_idx;

`ifdef LINK_TIMEOUT_EN
   logic [31:0]      timer_q,        timer_d;
   logic             rsp_err_q,      rsp_err_d;
   logic             abort_pulse;
`endif

   rr_arbiter #(
      .NREQ (NREQ),
      .ID_W (ID_W)
   ) u_rr_arbiter (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .any (arb_any),
      .idx (arb_idx)
   );

   always_comb begin
      state_d        = state_q;
      grant_d        = grant_q;
      rr_ptr_d       = rr_ptr_q;
      link_msg_d     = link_msg_q;
      link_key_d     = link_key_q;
      link_decrypt_d = link_decrypt_q;
      rsp_data_d     = rsp_data_q;
      jobs_done_d    = jobs_done_q;
      req_ready      = '0;
      link_start     = 1'b0;
      rsp_valid      = 1'b0;
`ifdef LINK_TIMEOUT_EN
      timer_d        = timer_q;
      rsp_err_d      = rsp_err_q;
      abort_pulse    = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               grant_d = arb_idx;
               state_d = ST_GRANT;
            end
         end

         ST_GRANT: begin
            req_ready[grant_q] = 1'b1;
            // A requester that withdrew before the handshake forfeits the
            // slot without advancing the round-robin pointer.
            if (req_valid[grant_q]) begin
               link_msg_d     = req_msg[int'(grant_q)*MSG_W +: MSG_W];
               link_key_d     = req_key[int'(grant_q)*KEY_W +: KEY_W];
               link_decrypt_d = req_decrypt[grant_q];
               rr_ptr_d       = (grant_q == ID_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;
               state_d        = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_START: begin
            link_start = 1'b1;
            state_d    = ST_WAIT;
`ifdef LINK_TIMEOUT_EN
            timer_d    = '0;
`endif
         end

         ST_WAIT: begin
            // link_done has priority over an expiring watchdog.
            if (link_done) begin
               rsp_data_d = link_result;
`ifdef LINK_TIMEOUT_EN
               rsp_err_d  = 1'b0;
`endif
               state_d    = ST_RESP;
`ifdef LINK_TIMEOUT_EN
            end else if (timer_q == 32'(TIMEOUT_CYCLES - 1)) begin
               abort_pulse = 1'b1;
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
               state_d     = ST_RESP;
            end else begin
               timer_d = timer_q + 32'd1;
`endif
            end
         end

         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               jobs_done_d = jobs_done_q + 16'd1;
               state_d     = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge in_clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments; the next-state block above uses blocking ones.
      if (rst) begin
         state_q        <= ST_IDLE;
         grant_q        <= '0;
         rr_ptr_q       <= '0;
         // NOTE: the payload registers are reset as well, because link_* and rsp_data must read zero after reset.
         link_msg_q     <= '0;
         link_key_q     <= '0;
         link_decrypt_q <= 1'b0;
         rsp_data_q     <= '0;
         jobs_done_q    <= '0;
`ifdef LINK_TIMEOUT_EN
         timer_q        <= '0;
         rsp_err_q      <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         grant_q        <= grant_d;
         rr_ptr_q       <= rr_ptr_d;
         link_msg_q     <= link_msg_d;
         link_key_q     <= link_key_d;
         link_decrypt_q <= link_decrypt_d;
         rsp_data_q     <= rsp_data_d;
         jobs_done_q    <= jobs_done_d;
`ifdef LINK_TIMEOUT_EN
         timer_q        <= timer_d;
         rsp_err_q      <= rsp_err_d;
`endif
      end
   end

   assign link_msg     = link_msg_q;
   assign link_key     = link_key_q;
   assign link_decrypt = link_decrypt_q;
   assign rsp_id       = grant_q;
   assign rsp_data     = rsp_data_q;
   assign jobs_done    = jobs_done_q;

`ifdef LINK_TIMEOUT_EN
   assign link_abort   = abort_pulse;
   assign rsp_err      = rsp_err_q;
`else
   assign link_abort   = 1'b0;
   assign rsp_err      = 1'b0;
`endif

endmodule

// File: doc/enc_job_scheduler.md
Name: enc_job_scheduler

Overview:
- Round-robin scheduler sharing one serial encrypt/decrypt link master among NREQ requesters.
- Accepts jobs (message, key, mode) through valid/ready handshakes and runs them one at a time.
- Presents each job on the link master's parallel side, pulses a start strobe, waits for the link's done strobe, then returns the result on a single response channel tagged with requester id.
- Sits between host-side job sources and the serial master/slave pair.

Parameters:
- nb, 4, message words; MSG_W = 32*nb bits
- nk, 8, key words; KEY_W = 32*nk bits
- NREQ, 4, number of requesters (2..8); ID_W = max(1, clog2(NREQ))
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT (used only with the feature macro)

Ports:
- in_clk, input, 1, sole clock, rising edge
- rst, input, 1, asynchronous active-high reset
- req_valid, input, NREQ, per-requester job valid
- req_ready, output, NREQ, per-requester accept; at most one bit set
- req_msg, input, NREQ*MSG_W, packed messages; requester i at slice i
- req_key, input, NREQ*KEY_W, packed keys
- req_decrypt, input, NREQ, mode per requester (1 = decrypt)
- link_msg, output, MSG_W, message to link master; held from capture to end of job
- link_key, output, KEY_W, key to link master; held from capture to end of job
- link_decrypt, output, 1, mode to link
- link_start, output, 1, one-cycle start pulse
- link_done, input, 1, one-cycle completion strobe from link
- link_result, input, MSG_W, result; valid while link_done=1
- link_abort, output, 1, one-cycle abort pulse (feature only)
- rsp_valid, output, 1, response valid
- rsp_ready, input, 1, response accept
- rsp_id, output, ID_W, requester index of the job
- rsp_data, output, MSG_W, result
- rsp_err, output, 1, job timed out
- jobs_done, output, 16, completed-job counter; wraps at 0xFFFF->0

Behaviour:
- Reset (asynchronous, any state): state=IDLE, rr_ptr=0, all outputs 0, link_msg/link_key cleared, jobs_done=0.
- IDLE: if any req_valid, pick the first set bit at or after rr_ptr (cyclic), register it as grant, go to GRANT. Otherwise stay.
- GRANT (1 cycle): req_ready[grant]=1.
  - If req_valid[grant]=1: capture msg/key/mode into link_* registers, rr_ptr=(grant+1) mod NREQ, go to START.
  - If req_valid dropped: no capture, rr_ptr unchanged, return to IDLE.
- START (1 cycle): link_start=1, go to WAIT.
- WAIT: on link_done, register link_result into rsp_data, rsp_err=0, go to RESP. link_done outside WAIT is ignored.
- RESP: rsp_valid=1 with rsp_id=grant. Hold rsp_valid/rsp_id/rsp_data/rsp_err stable until rsp_ready. On the handshake cycle: jobs_done+=1, go to IDLE, rsp_valid=0 next cycle.
- Latency:
  - req_valid at cycle t (IDLE) -> req_ready at t+1 -> link_start at t+2.
  - link_done at d -> rsp_valid at d+1.
  - Minimum job-to-job turnaround: 4 cycles plus link time.
- New requests are never accepted while a job is in flight. Non-granted requesters see req_ready=0 and must hold valid.
- link_* outputs keep their last job's values after RESP until the next capture.
- Reset mid-job: the job is dropped, no response is issued, and link_start is never re-issued.

Optional Feature:
- Macro: LINK_TIMEOUT_EN.
- Enabled: a counter clears on entry to WAIT and increments each WAIT cycle. On reaching TIMEOUT_CYCLES without link_done: link_abort=1 for one cycle, rsp_data=0, rsp_err=1, go to RESP. Errored jobs still increment jobs_done. If link_done and the timeout occur in the same cycle, link_done wins.
- Disabled: no counter, WAIT has no exit except link_done, link_abort and rsp_err tied 0. Ports remain present.

Decomposition:
- Shared package: state encoding (IDLE, GRANT, START, WAIT, RESP), MSG_W/KEY_W derivation, ID_W function.
- One sub-module: rr_arbiter, a combinational first-set-at-or-after-pointer search over NREQ bits. The FSM and datapath stay in the top level.

Test Plan:
- Single job: req_valid=0001, msg=0x00112233..., decrypt=0 -> req_ready[0] at t+1, link_start at t+2, link_msg matches. link_done with result 0x69C4E0D8... -> rsp_valid next cycle, rsp_id=0, rsp_data=result, jobs_done=1.
- Fairness: req_valid=1111 held for 8 jobs -> grant order 0,1,2,3,0,1,2,3.
- Backpressure: rsp_ready=0 for 10 cycles -> rsp_* stable, no new req_ready. rsp_ready=1 -> IDLE; next grant on the following cycle.
- Valid dropped in GRANT (req 2) -> no link_start, rr_ptr unchanged, req 2 granted again on re-assert.
- Reset asserted in WAIT -> outputs 0 immediately. Late link_done is ignored and no rsp_valid appears.
- LINK_TIMEOUT_EN, TIMEOUT_CYCLES=16, no link_done -> link_abort pulse after 16 WAIT cycles, rsp_err=1, rsp_data=0.
